// File: rtl/alu_md_decoder_pkg.sv
// Shared encodings for the EX-stage ALU decoder and its RV32M mul/div sequencer.
package alu_md_decoder_pkg;

  // ALUOp classes produced by main_decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_LUI   = 2'b11;

  // ALUControl codes (zero-extended to CTRL_W at the top level)
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_PASSB = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1111;

  // Base-ISA funct3 for ALUOp=10
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  // RV32M funct3 op codes
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  // funct3[2] separates the divide group from the multiply group
  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/alu_md_decoder_md_seq.sv
// Mul/div sequencer: issues start to the iterative unit, counts its latency,
// holds the pipeline, and presents a one-cycle result-valid or abort pulse.
module md_seq
  import alu_md_decoder_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       is_md,
  input  logic       flush,
  input  logic [2:0] funct3,
  output logic [2:0] md_op,
  output logic       md_start,
  output logic       md_abort,
  output logic       md_valid,
  output logic       stall
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT) + 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (flush) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (is_md) begin
            state_d = MD_BUSY;
            op_d    = funct3;
            cnt_d   = f3_is_div(funct3) ? DIV_LOAD : MUL_LOAD;
          end
        end
        MD_BUSY: begin
          if (cnt_q == '0) begin
            state_d = MD_DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        MD_DONE: begin
          state_d = MD_IDLE;
        end
        default: begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // md_op tracks funct3 directly on the issue cycle so it accompanies md_start
  always_comb begin
    md_start = 1'b0;
    md_abort = 1'b0;
    md_valid = 1'b0;
    stall    = 1'b0;
    md_op    = op_q;
    case (state_q)
      MD_IDLE: begin
        if (is_md && !flush) begin
          md_start = 1'b1;
          stall    = 1'b1;
          md_op    = funct3;
        end
        md_abort = is_md && flush;
      end
      MD_BUSY: begin
        stall    = !flush;
        md_abort = flush;
      end
      MD_DONE: begin
        md_valid = !flush;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
    // The unit shares this reset, so no pulses escape while it is asserted
    if (reset) begin
      md_start = 1'b0;
      md_abort = 1'b0;
      md_valid = 1'b0;
    end
  end

endmodule

// File: rtl/alu_md_decoder.sv
// EX-stage ALU decoder with RV32M sequencing and a saturating stall counter.
module alu_md_decoder
  import alu_md_decoder_pkg::*;
#(
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 33,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              flush,
  input  logic              opcodebit5,
  input  logic [2:0]        funct3,
  input  logic              funct7bit5,
  input  logic              funct7bit0,
  input  logic [1:0]        ALUOp,
  output logic [CTRL_W-1:0] ALUControl,
  output logic [2:0]        md_op,
  output logic              md_start,
  output logic              md_abort,
  output logic              md_valid,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic             is_md;
  logic [3:0]       alu_code;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    is_md = valid_i && (ALUOp == ALUOP_RTYPE) && opcodebit5 && funct7bit0;
  end

  always_comb begin
    alu_code = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD:   alu_code = ALU_ADD;
      ALUOP_SUB:   alu_code = ALU_SUB;
      ALUOP_LUI:   alu_code = ALU_PASSB;
      ALUOP_RTYPE: begin
        case (funct3)
          F3_ADDSUB: alu_code = (opcodebit5 && funct7bit5) ? ALU_SUB : ALU_ADD;
          F3_SLL:    alu_code = ALU_SLL;
          F3_SLT:    alu_code = ALU_SLT;
          F3_SLTU:   alu_code = ALU_SLTU;
          F3_XOR:    alu_code = ALU_XOR;
          F3_SR:     alu_code = funct7bit5 ? ALU_SRA : ALU_SRL;
          F3_OR:     alu_code = ALU_OR;
          F3_AND:    alu_code = ALU_AND;
          default:   alu_code = ALU_ADD;
        endcase
      end
      default:     alu_code = ALU_ADD;
    endcase
    if (is_md) begin
      alu_code = ALU_ADD;
    end
  end

  always_comb begin
    ALUControl = CTRL_W'(alu_code);
  end

  md_seq #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) u_md_seq (
    .clk     (clk),
    .reset   (reset),
    .is_md   (is_md),
    .flush   (flush),
    .funct3  (funct3),
    .md_op   (md_op),
    .md_start(md_start),
    .md_abort(md_abort),
    .md_valid(md_valid),
    .stall   (stall)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_alu_md_decoder.sv
// Scoreboard bench: stimulus queues expected md_start/md_abort/md_valid events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_alu_md_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        flush;
  logic        opcodebit5;
  logic [2:0]  funct3;
  logic        funct7bit5;
  logic        funct7bit0;
  logic [1:0]  ALUOp;
  logic [3:0]  ALUControl;
  logic [2:0]  md_op;
  logic        md_start;
  logic        md_abort;
  logic        md_valid;
  logic        stall;
  logic [31:0] stall_cnt;

  logic [3:0]  s_ALUControl;
  logic [2:0]  s_md_op;
  logic        s_md_start;
  logic        s_md_abort;
  logic        s_md_valid;
  logic        s_stall;
  logic [3:0]  s_stall_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  typedef struct packed {
    logic [2:0]  kind;   // {start, abort, valid}
    logic [2:0]  op;
    int unsigned cyc;
  } ev_t;

  ev_t exp_q[$];

  localparam logic [2:0] EV_START = 3'b100;
  localparam logic [2:0] EV_ABORT = 3'b010;
  localparam logic [2:0] EV_VALID = 3'b001;

  typedef struct packed {
    logic [1:0] aluop;
    logic [2:0] f3;
    logic       op5;
    logic       f7b5;
    logic [3:0] exp;
  } dec_t;

  dec_t dec_tab[13];

  alu_md_decoder #(
    .CTRL_W (4),
    .MUL_LAT(3),
    .DIV_LAT(33),
    .CNT_W  (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_i   (valid_i),
    .flush     (flush),
    .opcodebit5(opcodebit5),
    .funct3    (funct3),
    .funct7bit5(funct7bit5),
    .funct7bit0(funct7bit0),
    .ALUOp     (ALUOp),
    .ALUControl(ALUControl),
    .md_op     (md_op),
    .md_start  (md_start),
    .md_abort  (md_abort),
    .md_valid  (md_valid),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  alu_md_decoder #(
    .CTRL_W (4),
    .MUL_LAT(3),
    .DIV_LAT(33),
    .CNT_W  (4)
  ) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .valid_i   (valid_i),
    .flush     (flush),
    .opcodebit5(opcodebit5),
    .funct3    (funct3),
    .funct7bit5(funct7bit5),
    .funct7bit0(funct7bit0),
    .ALUOp     (ALUOp),
    .ALUControl(s_ALUControl),
    .md_op     (s_md_op),
    .md_start  (s_md_start),
    .md_abort  (s_md_abort),
    .md_valid  (s_md_valid),
    .stall     (s_stall),
    .stall_cnt (s_stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_inputs();
    valid_i    = 1'b0;
    flush      = 1'b0;
    opcodebit5 = 1'b0;
    funct3     = 3'b000;
    funct7bit5 = 1'b0;
    funct7bit0 = 1'b0;
    ALUOp      = 2'b00;
  endtask

  task automatic set_md(input logic [2:0] f3);
    valid_i    = 1'b1;
    ALUOp      = 2'b10;
    opcodebit5 = 1'b1;
    funct7bit0 = 1'b1;
    funct7bit5 = 1'b0;
    funct3     = f3;
  endtask

  task automatic push(input logic [2:0] kind, input logic [2:0] op, input int unsigned c);
    ev_t e;
    e.kind = kind;
    e.op   = op;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse the DUT raises must match the head of the queue
  always @(negedge clk) begin
    if (md_start || md_abort || md_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got start=%0b abort=%0b valid=%0b, expected none (cycle %0d)",
                 md_start, md_abort, md_valid, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_kind", {61'd0, md_start, md_abort, md_valid}, {61'd0, e.kind});
        check("event_cycle", 64'(cyc), 64'(e.cyc));
        if (e.kind != EV_ABORT) check("event_md_op", 64'(md_op), 64'(e.op));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned c;
    logic [31:0] s0;
    logic        op_ok;

    dec_tab = '{
      '{2'b00, 3'b000, 1'b0, 1'b0, 4'b0000},
      '{2'b01, 3'b000, 1'b0, 1'b0, 4'b0001},
      '{2'b11, 3'b000, 1'b0, 1'b0, 4'b1001},
      '{2'b10, 3'b000, 1'b1, 1'b1, 4'b0001},
      '{2'b10, 3'b000, 1'b0, 1'b1, 4'b0000},
      '{2'b10, 3'b001, 1'b1, 1'b0, 4'b0100},
      '{2'b10, 3'b010, 1'b1, 1'b0, 4'b0101},
      '{2'b10, 3'b011, 1'b1, 1'b0, 4'b1000},
      '{2'b10, 3'b100, 1'b1, 1'b0, 4'b0110},
      '{2'b10, 3'b101, 1'b1, 1'b1, 4'b1111},
      '{2'b10, 3'b101, 1'b1, 1'b0, 4'b0111},
      '{2'b10, 3'b110, 1'b1, 1'b0, 4'b0011},
      '{2'b10, 3'b111, 1'b1, 1'b0, 4'b0010}
    };

    clr_inputs();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    @(negedge clk);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    check("reset_md_op", 64'(md_op), 64'd0);
    check("reset_pulses", {61'd0, md_start, md_abort, md_valid}, 64'd0);
    tick(1);

    // Combinational decode, no M ops
    foreach (dec_tab[i]) begin
      valid_i    = 1'b1;
      ALUOp      = dec_tab[i].aluop;
      funct3     = dec_tab[i].f3;
      opcodebit5 = dec_tab[i].op5;
      funct7bit5 = dec_tab[i].f7b5;
      funct7bit0 = 1'b0;
      #1;
      check($sformatf("decode_%0d", i), 64'(ALUControl), 64'(dec_tab[i].exp));
    end
    clr_inputs();
    tick(1);

    // MUL: start at C, stall C..C+3, md_valid at C+4
    c  = cyc;
    s0 = stall_cnt;
    set_md(3'b000);
    push(EV_START, 3'b000, c);
    push(EV_VALID, 3'b000, c + 4);
    tick(5);
    clr_inputs();
    check("mul_stall_cycles", 64'(stall_cnt - s0), 64'd4);
    tick(2);

    // DIVU: 34 stall cycles, md_op held at 101
    c  = cyc;
    s0 = stall_cnt;
    set_md(3'b101);
    #1;
    check("divu_alucontrol_forced", 64'(ALUControl), 64'd0);
    push(EV_START, 3'b101, c);
    push(EV_VALID, 3'b101, c + 34);
    op_ok = 1'b1;
    for (int i = 0; i < 35; i++) begin
      tick(1);
      if (i < 34 && md_op !== 3'b101) op_ok = 1'b0;
    end
    clr_inputs();
    check("divu_md_op_held", 64'(op_ok), 64'd1);
    check("divu_stall_cycles", 64'(stall_cnt - s0), 64'd34);
    tick(2);

    // DIV flushed in its 10th BUSY cycle
    c  = cyc;
    s0 = stall_cnt;
    set_md(3'b100);
    push(EV_START, 3'b100, c);
    push(EV_ABORT, 3'b000, c + 10);
    tick(10);
    flush   = 1'b1;
    valid_i = 1'b0;
    @(negedge clk);
    check("flush_busy_stall", 64'(stall), 64'd0);
    tick(1);
    flush = 1'b0;
    #1;
    check("flush_next_stall", 64'(stall), 64'd0);
    check("flush_stall_cycles", 64'(stall_cnt - s0), 64'd10);
    tick(40);

    // Flush while IDLE is issuing: abort, no start
    c = cyc;
    set_md(3'b001);
    flush = 1'b1;
    push(EV_ABORT, 3'b000, c);
    #1;
    check("flush_issue_stall", 64'(stall), 64'd0);
    tick(1);
    clr_inputs();
    tick(2);

    // Back-to-back MULHU: starts 5 cycles apart
    c = cyc;
    set_md(3'b011);
    #1;
    check("mulhu_alucontrol_forced", 64'(ALUControl), 64'd0);
    push(EV_START, 3'b011, c);
    push(EV_VALID, 3'b011, c + 4);
    push(EV_START, 3'b011, c + 5);
    push(EV_VALID, 3'b011, c + 9);
    tick(10);
    clr_inputs();
    tick(2);

    // Reset while BUSY
    c = cyc;
    set_md(3'b000);
    push(EV_START, 3'b000, c);
    tick(2);
    reset = 1'b1;
    clr_inputs();
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy_stall", 64'(stall), 64'd0);
    check("reset_busy_stall_cnt", 64'(stall_cnt), 64'd0);
    check("reset_busy_sat_cnt", 64'(s_stall_cnt), 64'd0);
    tick(6);

    // 20 stall cycles: 32-bit counter reads 20, 4-bit counter pins at 15
    c = cyc;
    set_md(3'b100);
    push(EV_START, 3'b100, c);
    push(EV_ABORT, 3'b000, c + 20);
    tick(20);
    flush   = 1'b1;
    valid_i = 1'b0;
    tick(1);
    clr_inputs();
    check("cnt_20_stalls", 64'(stall_cnt), 64'd20);
    check("cnt_saturated", 64'(s_stall_cnt), 64'd15);
    tick(4);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
